// File: rtl/rf_variable_bank.sv
// rf_variable_bank
//   Bank of NUM_VARS variable slots shared by NUM_CH requester channels.
//   Each slot has a static declared width (var_width, 6 bits per slot,
//   0 = slot absent, values above DATA_W clamp to DATA_W). One request is
//   outstanding at a time; channels are served round-robin.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   var_width    : per-slot declared width, 6 bits each
//   req_valid/_ready/_op/_handle/_wdata : per-channel request bus
//                  (op 00 GET, 01 SET, 10 ENUM, 11 reserved -> error)
//   rsp_valid    : per-channel response valid (owning channel only)
//   rsp_ready    : per-channel response consume
//   rsp_data/_handle/_err/_last : shared response payload
module rf_variable_bank #(
  parameter int NUM_VARS = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 2,
  localparam int HW      = $clog2(NUM_VARS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_VARS*6-1:0]    var_width,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*2-1:0]      req_op,
  input  logic [NUM_CH*HW-1:0]     req_handle,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  input  logic [NUM_CH-1:0]        rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [HW-1:0]            rsp_handle,
  output logic                     rsp_err,
  output logic                     rsp_last
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DATA_W-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP, ENUM} state_e;
  typedef enum logic [1:0] {
    OP_GET  = 2'b00,
    OP_SET  = 2'b01,
    OP_ENUM = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     owner_q, owner_d;
  op_e               op_q, op_d;
  logic [HW-1:0]     hnd_q, hnd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_q [NUM_VARS];
  logic [DATA_W-1:0] mem_d [NUM_VARS];

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [HW-1:0]     rsp_handle_q, rsp_handle_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_last_q, rsp_last_d;

  // Per-slot declared width and presence
  logic [5:0]          w_arr [NUM_VARS];
  logic [NUM_VARS-1:0] pres;

  for (genvar g = 0; g < NUM_VARS; g++) begin : g_slot
    assign w_arr[g] = var_width[g*6 +: 6];
    assign pres[g]  = (w_arr[g] != 6'd0);
  end

  // Round-robin arbiter: first asserted channel at or after the pointer
  logic        gnt_any;
  int unsigned win_i;

  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    win_i   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(ptr_q) + k) % NUM_CH;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        win_i   = idx;
      end
    end
  end

  // Decode of the captured GET/SET command
  logic              hdl_ok;
  logic [HW-1:0]     hidx;
  logic [5:0]        cur_w;
  logic [5:0]        eff_w;
  logic [DATA_W-1:0] set_val;
  logic              cmd_err;

  always_comb begin
    hdl_ok  = (32'(hnd_q) < NUM_VARS);
    hidx    = hdl_ok ? hnd_q : '0;
    cur_w   = w_arr[hidx];
    eff_w   = (cur_w > 6'(DATA_W)) ? 6'(DATA_W) : cur_w;
    // Shifting by the full width yields zero, so a full-width slot keeps all bits
    set_val = wdata_q & ~(ONES << eff_w);
    cmd_err = (op_q == OP_RSV) || !hdl_ok || (cur_w == 6'd0);
  end

  // ENUM scan: first present slot at/after the start, and whether another follows.
  // The start is derived from the beat currently on the bus, so no scan register is needed.
  int unsigned en_start;
  int unsigned en_sel;
  logic        en_found;
  logic        en_more;

  always_comb begin
    en_start = rsp_valid_q ? 32'(rsp_handle_q) + 32'd1 : 32'd0;
    en_found = 1'b0;
    en_sel   = 0;
    en_more  = 1'b0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      if (!en_found && (i >= en_start) && pres[i]) begin
        en_found = 1'b1;
        en_sel   = i;
      end
    end
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      if (en_found && (i > en_sel) && pres[i]) en_more = 1'b1;
    end
  end

  logic rsp_fire;
  assign rsp_fire = rsp_valid_q && rsp_ready[owner_q];

  // Next-state / output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    hnd_d        = hnd_q;
    wdata_d      = wdata_q;
    mem_d        = mem_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_handle_d = rsp_handle_q;
    rsp_err_d    = rsp_err_q;
    rsp_last_d   = rsp_last_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready[win_i] = 1'b1;
          owner_d          = CW'(win_i);
          op_d             = op_e'(req_op[2*win_i +: 2]);
          hnd_d            = req_handle[HW*win_i +: HW];
          wdata_d          = req_wdata[DATA_W*win_i +: DATA_W];
          ptr_d            = CW'((win_i + 1) % NUM_CH);
          state_d          = EXEC;
        end
      end
      EXEC: begin
        if ((op_q == OP_SET) && !cmd_err) mem_d[hidx] = set_val;
        state_d = (op_q == OP_ENUM) ? ENUM : RESP;
      end
      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = cmd_err ? '0 : mem_q[hidx];
          rsp_handle_d = hnd_q;
          rsp_err_d    = cmd_err;
          rsp_last_d   = 1'b1;
        end else if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      ENUM: begin
        // Beats follow each other back-to-back: a consumed non-final beat
        // is replaced by the next present slot in the same cycle.
        if (!rsp_valid_q || (rsp_fire && !rsp_last_q)) begin
          rsp_valid_d = 1'b1;
          if (en_found) begin
            rsp_data_d   = mem_q[en_sel];
            rsp_handle_d = HW'(en_sel);
            rsp_err_d    = 1'b0;
            rsp_last_d   = !en_more;
          end else begin
            rsp_data_d   = '0;
            rsp_handle_d = '0;
            rsp_err_d    = 1'b1;
            rsp_last_d   = 1'b1;
          end
        end else if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      op_q         <= OP_GET;
      hnd_q        <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_handle_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_last_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_VARS; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      hnd_q        <= hnd_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_handle_q <= rsp_handle_d;
      rsp_err_q    <= rsp_err_d;
      rsp_last_q   <= rsp_last_d;
      mem_q        <= mem_d;
    end
  end

  always_comb begin
    rsp_valid          = '0;
    rsp_valid[owner_q] = rsp_valid_q;
  end

  assign rsp_data   = rsp_data_q;
  assign rsp_handle = rsp_handle_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_last   = rsp_last_q;

endmodule
